// File: rtl/eth_tx_pkg.sv
// Shared widths, FSM state encoding and a pointer-width helper for the
// Ethernet TX header+payload arbiter.
package eth_tx_pkg;

    localparam int MAC_W  = 48;
    localparam int TYPE_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    // Index width for a requester count; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr.sv
// Combinational round-robin picker: the first requester after ptr wins,
// wrapping around, with ptr itself considered last.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    always_comb begin
        int  idx;
        logic found;
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(ptr) + off) % N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-level arbiter sharing one Ethernet TX header+payload port between
// N_REQ requesters; a granted requester keeps the port until its tlast beat.
module eth_tx_arbiter
    import eth_tx_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          s_hdr_valid,
    output logic [N_REQ-1:0]          s_hdr_ready,
    input  logic [MAC_W*N_REQ-1:0]    s_dest_mac,
    input  logic [MAC_W*N_REQ-1:0]    s_src_mac,
    input  logic [TYPE_W*N_REQ-1:0]   s_eth_type,
    input  logic [DATA_W*N_REQ-1:0]   s_tdata,
    input  logic [N_REQ-1:0]          s_tvalid,
    input  logic [N_REQ-1:0]          s_tlast,
    input  logic [N_REQ-1:0]          s_tuser,
    output logic [N_REQ-1:0]          s_tready,
    output logic                      m_hdr_valid,
    input  logic                      m_hdr_ready,
    output logic [MAC_W-1:0]          m_dest_mac,
    output logic [MAC_W-1:0]          m_src_mac,
    output logic [TYPE_W-1:0]         m_eth_type,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    output logic                      m_tuser,
    input  logic                      m_tready,
    input  logic                      m_busy,
    output logic [N_REQ-1:0]          grant,
    output logic [15:0]               frame_count
);

    localparam int PTR_W = idx_width(N_REQ);

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  g_idx;
    logic [N_REQ-1:0]  arb_grant;
    logic              in_hdr;
    logic              in_pay;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req   (s_hdr_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) g_idx = PTR_W'(i);
        end
    end

    assign in_hdr = (state == HDR);
    assign in_pay = (state == PAYLOAD);

    // The datapath is a pure mux on the registered owner; only the valid/ready
    // strobes are gated by state so nothing leaks out while idle.
    assign m_hdr_valid = in_hdr & s_hdr_valid[g_idx];
    assign m_dest_mac  = s_dest_mac[int'(g_idx)*MAC_W +: MAC_W];
    assign m_src_mac   = s_src_mac[int'(g_idx)*MAC_W +: MAC_W];
    assign m_eth_type  = s_eth_type[int'(g_idx)*TYPE_W +: TYPE_W];
    assign m_tdata     = s_tdata[int'(g_idx)*DATA_W +: DATA_W];
    assign m_tvalid    = in_pay & s_tvalid[g_idx];
    assign m_tlast     = in_pay & s_tlast[g_idx];
    assign m_tuser     = in_pay & s_tuser[g_idx];
    assign s_hdr_ready = grant & {N_REQ{in_hdr & m_hdr_ready}};
    assign s_tready    = grant & {N_REQ{in_pay & m_tready}};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= PTR_W'(N_REQ - 1);
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!m_busy && |s_hdr_valid) begin
                        grant <= arb_grant;
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (m_hdr_valid && m_hdr_ready) state <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (m_tvalid && m_tready && m_tlast) begin
                        state       <= IDLE;
                        grant       <= '0;
                        rr_ptr      <= g_idx;
                        frame_count <= frame_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
